// File: rtl/disp_pkg.sv
// Shared helpers and types for the N-channel dispatcher: width derivation
// and the per-channel status bundle.
package disp_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int unsigned calc_cw(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int unsigned calc_dw(input int unsigned nch);
    return (clog2(nch) < 1) ? 1 : clog2(nch);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } chan_status_t;

endpackage

// File: rtl/disp_fifo.sv
// One dispatcher channel: circular storage, pointers, occupancy count,
// decoded status flags and sticky overflow/underflow errors.
module disp_fifo
  import disp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_req,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_req,
  input  logic [CW-1:0]    i_afull_th,
  input  logic [CW-1:0]    i_aempty_th,
  input  logic             i_err_clear,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic [CW-1:0]    o_count,
  output chan_status_t     o_status,
  output logic             o_err_overflow,
  output logic             o_err_underflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_err_ovf;
  logic             r_err_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // full/empty come from the count; pointers wrap silently and are never compared.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = i_wr_req && !w_full;
  assign w_rd_acc = i_rd_req && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_rd_acc;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_err_ovf <= (i_wr_req && w_full)  || (r_err_ovf && !i_err_clear);
      r_err_udf <= (i_rd_req && w_empty) || (r_err_udf && !i_err_clear);
    end
  end

  always_comb begin
    o_status              = '0;
    o_status.empty        = w_empty;
    o_status.full         = w_full;
    o_status.almost_full  = (i_afull_th != '0) && (r_count >= i_afull_th);
    o_status.almost_empty = (r_count <= i_aempty_th);
  end

  assign o_rd_data       = r_rd_data;
  assign o_rd_valid      = r_rd_valid;
  assign o_count         = r_count;
  assign o_err_overflow  = r_err_ovf;
  assign o_err_underflow = r_err_udf;

endmodule

// File: rtl/disp_fifo_n.sv
// N-channel dispatcher: steers a tagged word stream into NCH independent
// FIFOs, each with its own read port, status flags and sticky errors.
module disp_fifo_n
  import disp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = calc_cw(DEPTH),
  localparam int unsigned DW = calc_dw(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [DW-1:0]      in_dest,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH-1:0]     read,
  input  logic [CW-1:0]      afull_th,
  input  logic [CW-1:0]      aempty_th,
  input  logic               err_clear,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]     out_valid,
  output logic [NCH*CW-1:0]  count,
  output logic [NCH-1:0]     empty,
  output logic [NCH-1:0]     full,
  output logic [NCH-1:0]     almost_full,
  output logic [NCH-1:0]     almost_empty,
  output logic [NCH-1:0]     err_overflow,
  output logic [NCH-1:0]     err_underflow,
  output logic               err_baddest
);

  chan_status_t w_status [NCH];
  logic         w_dest_ok;
  logic         w_sel_full;
  logic         r_err_baddest;

  // Widened by one bit so the range check stays meaningful when NCH is a power of two.
  assign w_dest_ok = ({1'b0, in_dest} < (DW + 1)'(NCH));

  always_comb begin
    w_sel_full = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (in_dest == DW'(i)) w_sel_full = full[i];
    end
  end

  assign in_ready = w_dest_ok && !w_sel_full;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic w_wr_req;

    assign w_wr_req = in_valid && w_dest_ok && (in_dest == DW'(g));

    disp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk             (clk),
      .reset           (reset),
      .i_wr_req        (w_wr_req),
      .i_wr_data       (in_data),
      .i_rd_req        (read[g]),
      .i_afull_th      (afull_th),
      .i_aempty_th     (aempty_th),
      .i_err_clear     (err_clear),
      .o_rd_data       (out_data[g*WIDTH +: WIDTH]),
      .o_rd_valid      (out_valid[g]),
      .o_count         (count[g*CW +: CW]),
      .o_status        (w_status[g]),
      .o_err_overflow  (err_overflow[g]),
      .o_err_underflow (err_underflow[g])
    );

    assign empty[g]        = w_status[g].empty;
    assign full[g]         = w_status[g].full;
    assign almost_full[g]  = w_status[g].almost_full;
    assign almost_empty[g] = w_status[g].almost_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_baddest <= 1'b0;
    end else begin
      r_err_baddest <= (in_valid && !w_dest_ok) || (r_err_baddest && !err_clear);
    end
  end

  assign err_baddest = r_err_baddest;

endmodule

// File: tb/tb_disp_fifo_n.sv
// Self-checking bench for disp_fifo_n using queue-based channel models.
module tb_disp_fifo_n;

  // NCH=5 leaves in_dest codes 5..7 available as out-of-range destinations.
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned DW    = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WIDTH-1:0]     in_data;
  logic [DW-1:0]        in_dest;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH-1:0]       read;
  logic [CW-1:0]        afull_th;
  logic [CW-1:0]        aempty_th;
  logic                 err_clear;
  logic [NCH*WIDTH-1:0] out_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH*CW-1:0]    count;
  logic [NCH-1:0]       empty, full, almost_full, almost_empty;
  logic [NCH-1:0]       err_overflow, err_underflow;
  logic                 err_baddest;

  disp_fifo_n #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .read(read),
    .afull_th(afull_th), .aempty_th(aempty_th), .err_clear(err_clear),
    .out_data(out_data), .out_valid(out_valid), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_baddest(err_baddest)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mq [NCH][$];
  logic [WIDTH-1:0] m_data [NCH];
  logic [NCH-1:0]   m_valid, m_ovf, m_udf;
  logic             m_bad;
  int               n_pass = 0;
  int               n_total = 0;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      m_data[i] = '0;
    end
    m_valid = '0; m_ovf = '0; m_udf = '0; m_bad = 1'b0;
  endtask

  // Applies the currently driven inputs to the model, then crosses one edge.
  task automatic tick();
    int sz [NCH];
    for (int i = 0; i < NCH; i++) sz[i] = mq[i].size();
    if (err_clear) begin m_ovf = '0; m_udf = '0; m_bad = 1'b0; end
    for (int i = 0; i < NCH; i++) begin
      m_valid[i] = 1'b0;
      if (read[i]) begin
        if (sz[i] == 0) m_udf[i] = 1'b1;
        else begin m_data[i] = mq[i].pop_front(); m_valid[i] = 1'b1; end
      end
    end
    if (in_valid) begin
      if (int'(in_dest) >= NCH) m_bad = 1'b1;
      else if (sz[in_dest] == DEPTH) m_ovf[in_dest] = 1'b1;
      else mq[in_dest].push_back(in_data);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [NCH*CW-1:0] exp_count();
    logic [NCH*CW-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*CW +: CW] = CW'(mq[i].size());
    return r;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] exp_data();
    logic [NCH*WIDTH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*WIDTH +: WIDTH] = m_data[i];
    return r;
  endfunction

  function automatic void exp_flags(output logic [NCH-1:0] e, f, af, ae);
    for (int i = 0; i < NCH; i++) begin
      e[i]  = (mq[i].size() == 0);
      f[i]  = (mq[i].size() == DEPTH);
      af[i] = (afull_th != 0) && (mq[i].size() >= int'(afull_th));
      ae[i] = (mq[i].size() <= int'(aempty_th));
    end
  endfunction

  function automatic logic exp_ready();
    if (int'(in_dest) >= NCH) return 1'b0;
    return mq[in_dest].size() < DEPTH;
  endfunction

  task automatic idle();
    in_valid = 1'b0; read = '0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_total++; if (count !== '0) $display("FAIL rst_count got=%h exp=0", count); else n_pass++;
    n_total++; if (empty !== '1) $display("FAIL rst_empty got=%b exp=11111", empty); else n_pass++;
    n_total++; if (full !== '0 || almost_full !== '0) $display("FAIL rst_full got=%b/%b exp=0/0", full, almost_full); else n_pass++;
    n_total++; if (almost_empty !== '1) $display("FAIL rst_aempty got=%b exp=11111", almost_empty); else n_pass++;
    n_total++; if (out_valid !== '0 || out_data !== '0) $display("FAIL rst_out got=%b/%h exp=0/0", out_valid, out_data); else n_pass++;
    n_total++; if (err_overflow !== '0 || err_underflow !== '0 || err_baddest !== 1'b0)
      $display("FAIL rst_err got=%b/%b/%b exp=0", err_overflow, err_underflow, err_baddest); else n_pass++;
  endtask

  task automatic test_ch2_fill();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_dest = 3'd2; in_data = vals[k];
      tick();
      n_total++; if (int'(count[2*CW +: CW]) != k + 1) $display("FAIL ch2_count got=%0d exp=%0d", count[2*CW +: CW], k + 1); else n_pass++;
      n_total++; if (almost_empty[2] !== (k == 0)) $display("FAIL ch2_aempty got=%b exp=%b", almost_empty[2], k == 0); else n_pass++;
      n_total++; if (almost_full[2] !== (k == 2)) $display("FAIL ch2_afull got=%b exp=%b", almost_full[2], k == 2); else n_pass++;
      n_total++; if ((empty & 5'b11011) !== 5'b11011) $display("FAIL ch2_others got=%b exp=11x11", empty); else n_pass++;
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      read[2] = 1'b1;
      tick();
      n_total++; if (out_data[2*WIDTH +: WIDTH] !== vals[k]) $display("FAIL ch2_drain got=%h exp=%h", out_data[2*WIDTH +: WIDTH], vals[k]); else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_full_overflow();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_dest = 3'd0; in_data = 8'(8'h10 + k);
      tick();
    end
    in_valid = 1'b0; in_dest = 3'd0; #1;
    n_total++; if (full[0] !== 1'b1) $display("FAIL ch0_full got=%b exp=1", full[0]); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL ch0_ready got=%b exp=0", in_ready); else n_pass++;
    in_valid = 1'b1; in_data = 8'h14;
    tick();
    n_total++; if (err_overflow !== 5'b00001) $display("FAIL ch0_ovf got=%b exp=00001", err_overflow); else n_pass++;
    n_total++; if (count[0 +: CW] !== 3'd4) $display("FAIL ch0_cnt4 got=%0d exp=4", count[0 +: CW]); else n_pass++;
    idle();
    for (int k = 0; k < 4; k++) begin
      read[0] = 1'b1;
      tick();
      n_total++; if (out_valid[0] !== 1'b1 || out_data[0 +: WIDTH] !== 8'(8'h10 + k))
        $display("FAIL ch0_read got=%b/%h exp=1/%h", out_valid[0], out_data[0 +: WIDTH], 8'(8'h10 + k)); else n_pass++;
    end
    idle();
    tick();
    n_total++; if (out_valid[0] !== 1'b0) $display("FAIL ch0_pulse got=%b exp=0", out_valid[0]); else n_pass++;
    err_clear = 1'b1; tick(); idle();
    n_total++; if (err_overflow !== '0) $display("FAIL ch0_ovf_clr got=%b exp=0", err_overflow); else n_pass++;
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; in_dest = 3'd1; in_data = 8'd0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      in_valid = (k < 10); in_data = 8'(k); read[1] = 1'b1;
      tick();
      n_total++; if (out_valid[1] !== 1'b1 || out_data[WIDTH +: WIDTH] !== 8'(k - 1))
        $display("FAIL wrap_data got=%b/%h exp=1/%h", out_valid[1], out_data[WIDTH +: WIDTH], 8'(k - 1)); else n_pass++;
      n_total++; if (count[CW +: CW] !== ((k < 10) ? 3'd1 : 3'd0)) $display("FAIL wrap_count got=%0d exp=%0d", count[CW +: CW], (k < 10) ? 1 : 0); else n_pass++;
    end
    in_valid = 1'b0; read[1] = 1'b1;
    tick();
    n_total++; if (err_underflow !== 5'b00010) $display("FAIL udf_flag got=%b exp=00010", err_underflow); else n_pass++;
    n_total++; if (out_data[WIDTH +: WIDTH] !== 8'd9 || out_valid[1] !== 1'b0)
      $display("FAIL udf_hold got=%h/%b exp=09/0", out_data[WIDTH +: WIDTH], out_valid[1]); else n_pass++;
    idle(); err_clear = 1'b1; tick(); idle();
    n_total++; if (err_underflow !== '0) $display("FAIL udf_clr got=%b exp=0", err_underflow); else n_pass++;
  endtask

  task automatic test_baddest();
    in_valid = 1'b1; in_dest = 3'd5; in_data = 8'($urandom); #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bad_ready got=%b exp=0", in_ready); else n_pass++;
    tick();
    n_total++; if (err_baddest !== 1'b1) $display("FAIL bad_set got=%b exp=1", err_baddest); else n_pass++;
    n_total++; if (count !== '0) $display("FAIL bad_count got=%h exp=0", count); else n_pass++;
    in_valid = 1'b0; err_clear = 1'b1;
    tick();
    n_total++; if (err_baddest !== 1'b0) $display("FAIL bad_clr got=%b exp=0", err_baddest); else n_pass++;
    in_valid = 1'b1; in_dest = 3'd6; err_clear = 1'b0; tick();
    in_dest = 3'd7; err_clear = 1'b1; tick();
    n_total++; if (err_baddest !== 1'b1) $display("FAIL bad_clr_race got=%b exp=1", err_baddest); else n_pass++;
    idle(); err_clear = 1'b1; tick(); idle();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_dest = 3'd3; in_data = 8'(8'hE0 + k);
      tick();
    end
    idle();
    #3 reset = 1'b1;
    #1;
    n_total++; if (count !== '0 || empty !== '1) $display("FAIL arst_count got=%h/%b exp=0/11111", count, empty); else n_pass++;
    n_total++; if (almost_empty !== '1 || almost_full !== '0 || full !== '0)
      $display("FAIL arst_flags got=%b/%b/%b exp=11111/0/0", almost_empty, almost_full, full); else n_pass++;
    n_total++; if (out_data !== '0 || out_valid !== '0) $display("FAIL arst_out got=%h/%b exp=0/0", out_data, out_valid); else n_pass++;
    model_reset();
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_dest = 3'd3; in_data = 8'h5A;
    tick();
    idle(); read[3] = 1'b1;
    tick();
    n_total++; if (out_valid[3] !== 1'b1 || out_data[3*WIDTH +: WIDTH] !== 8'h5A)
      $display("FAIL arst_5a got=%b/%h exp=1/5a", out_valid[3], out_data[3*WIDTH +: WIDTH]); else n_pass++;
    idle(); tick();
  endtask

  task automatic test_random();
    logic [NCH-1:0] e, f, af, ae;
    afull_th  = CW'($urandom_range(0, DEPTH));
    aempty_th = CW'($urandom_range(0, DEPTH));
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_dest   = DW'($urandom_range(0, 7));
      in_data   = WIDTH'($urandom);
      read      = NCH'($urandom);
      err_clear = ($urandom_range(0, 15) == 0);
      #1;
      n_total++; if (in_ready !== exp_ready()) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready()); else n_pass++;
      tick();
      exp_flags(e, f, af, ae);
      n_total++; if (count !== exp_count()) $display("FAIL rnd_count c=%0d got=%h exp=%h", c, count, exp_count()); else n_pass++;
      n_total++; if ({empty, full, almost_full, almost_empty} !== {e, f, af, ae})
        $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, {empty, full, almost_full, almost_empty}, {e, f, af, ae}); else n_pass++;
      n_total++; if (out_valid !== m_valid || out_data !== exp_data())
        $display("FAIL rnd_out c=%0d got=%b/%h exp=%b/%h", c, out_valid, out_data, m_valid, exp_data()); else n_pass++;
      n_total++; if ({err_overflow, err_underflow, err_baddest} !== {m_ovf, m_udf, m_bad})
        $display("FAIL rnd_err c=%0d got=%b exp=%b", c, {err_overflow, err_underflow, err_baddest}, {m_ovf, m_udf, m_bad}); else n_pass++;
    end
    idle();
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_dest = '0;
    afull_th = 3'd3; aempty_th = 3'd1;
    idle();
    model_reset();
    test_reset();
    test_ch2_fill();
    test_full_overflow();
    test_wrap();
    test_baddest();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
